// File: rtl/dyt_sram_arb_if.sv
// Request/SRAM bundle for dyt_sram_arb; byte-strobe signals appear when DYT_SRAM_ARB_BYTE_STROBE_EN is defined.
// slave = arbiter view, master = requesters plus SRAM macro side.
interface dyt_sram_arb_if #(
   parameter int unsigned NPORTS = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [NPORTS-1:0]        port_ren;
   logic [NPORTS-1:0]        port_wen;
   logic [NPORTS*ADDR_W-1:0] port_addr;
   logic [NPORTS*DATA_W-1:0] port_w_data;
   logic [NPORTS-1:0]        port_ready;
   logic [DATA_W-1:0]        port_r_data;
   logic [ADDR_W-1:0]        sram_address;
   logic [DATA_W-1:0]        sram_w_data;
   logic                     sram_ren;
   logic                     sram_wen;
   logic [DATA_W-1:0]        sram_r_data;
`ifdef DYT_SRAM_ARB_BYTE_STROBE_EN
   logic [NPORTS*DATA_W/8-1:0] port_strb;
   logic [DATA_W/8-1:0]        sram_strb;

   modport slave (
      input  port_ren, port_wen, port_addr, port_w_data, port_strb, sram_r_data,
      output port_ready, port_r_data, sram_address, sram_w_data, sram_ren, sram_wen, sram_strb
   );
   modport master (
      output port_ren, port_wen, port_addr, port_w_data, port_strb, sram_r_data,
      input  port_ready, port_r_data, sram_address, sram_w_data, sram_ren, sram_wen, sram_strb
   );
`else
   modport slave (
      input  port_ren, port_wen, port_addr, port_w_data, sram_r_data,
      output port_ready, port_r_data, sram_address, sram_w_data, sram_ren, sram_wen
   );
   modport master (
      output port_ren, port_wen, port_addr, port_w_data, sram_r_data,
      input  port_ready, port_r_data, sram_address, sram_w_data, sram_ren, sram_wen
   );
`endif
endinterface

// File: rtl/dyt_sram_arb.sv
// Round-robin N-port arbiter/controller in front of a single-port SRAM.
// Optional byte strobes enabled by defining DYT_SRAM_ARB_BYTE_STROBE_EN.
module dyt_sram_arb #(
   parameter int unsigned NPORTS = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic            CLK,
   input  logic            nRST,
   dyt_sram_arb_if.slave   bus
);
   localparam int unsigned PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]        state, state_n;
   logic [PTR_W-1:0]  ptr, ptr_n;
   logic [PTR_W-1:0]  grant, grant_n;
   logic              op_wr, op_wr_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic [DATA_W-1:0] rdata_q, rdata_n;
   logic [NPORTS-1:0] ready_q, ready_n;
   logic              ren_q, ren_n;
   logic              wen_q, wen_n;
   logic [STRB_W-1:0] strb_q, strb_n;

   logic [NPORTS-1:0] req;
   logic              gnt_found;
   logic [PTR_W-1:0]  gnt_idx;
   logic [PTR_W-1:0]  cand;
   logic              gnt_wr;
   logic [STRB_W-1:0] gnt_strb;

   assign req = bus.port_ren | bus.port_wen;

   // First requesting port at or after the round-robin pointer.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NPORTS; k++) begin
         cand = PTR_W'((32'(ptr) + k) % NPORTS);
         if (!gnt_found && req[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign gnt_wr = bus.port_wen[gnt_idx];
`ifdef DYT_SRAM_ARB_BYTE_STROBE_EN
   assign gnt_strb = bus.port_strb[gnt_idx*STRB_W +: STRB_W];
`else
   assign gnt_strb = '1;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= S_IDLE;
         ptr     <= '0;
         grant   <= '0;
         op_wr   <= 1'b0;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         strb_q  <= '0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         grant   <= grant_n;
         op_wr   <= op_wr_n;
         cnt     <= cnt_n;
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         rdata_q <= rdata_n;
         ready_q <= ready_n;
         ren_q   <= ren_n;
         wen_q   <= wen_n;
         strb_q  <= strb_n;
      end
   end

   // Next state plus next value of every registered output.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      grant_n = grant;
      op_wr_n = op_wr;
      cnt_n   = cnt;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      rdata_n = rdata_q;
      ready_n = '0;
      ren_n   = 1'b0;
      wen_n   = 1'b0;
      strb_n  = '0;
      unique case (state)
         S_IDLE: begin
            if (gnt_found) begin
               grant_n = gnt_idx;
               op_wr_n = gnt_wr;
               addr_n  = bus.port_addr[gnt_idx*ADDR_W +: ADDR_W];
               wdata_n = bus.port_w_data[gnt_idx*DATA_W +: DATA_W];
               // An all-zero strobe write runs the full handshake without touching the SRAM.
               wen_n   = gnt_wr && (gnt_strb != '0);
               ren_n   = !gnt_wr;
               strb_n  = gnt_wr ? gnt_strb : '0;
               state_n = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (op_wr) begin
               ready_n = NPORTS'(1) << grant;
               state_n = S_DONE;
            end else begin
               ren_n   = 1'b1;
               cnt_n   = CNT_W'(RD_LAT - 1);
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               rdata_n = bus.sram_r_data;
               ready_n = NPORTS'(1) << grant;
               state_n = S_DONE;
            end else begin
               cnt_n   = cnt - 1'b1;
               ren_n   = 1'b1;
            end
         end
         default: begin
            ptr_n   = (grant == PTR_W'(NPORTS - 1)) ? '0 : grant + 1'b1;
            state_n = S_IDLE;
         end
      endcase
   end

   assign bus.port_ready   = ready_q;
   assign bus.port_r_data  = rdata_q;
   assign bus.sram_address = addr_q;
   assign bus.sram_w_data  = wdata_q;
   assign bus.sram_ren     = ren_q;
   assign bus.sram_wen     = wen_q;
`ifdef DYT_SRAM_ARB_BYTE_STROBE_EN
   assign bus.sram_strb    = strb_q;
`else
   logic unused_strb;
   assign unused_strb = ^strb_q;
`endif

endmodule

// File: doc/dyt_sram_arb.md
Name: dyt_sram_arb

Overview:
- Parametrised N-port arbiter and controller placed in front of the single-port Xilinx SRAM.
- Successor to the single CPU-to-SRAM connection: multiple requesters (I-fetch, D-mem, debug/DMA) share one SRAM.
- Adds a req/ready handshake per port, round-robin fairness, configurable data/address width and configurable SRAM read latency.
- Sits between the core's memory requesters and the SRAM macro.

Parameters:
- NPORTS, 2: number of requester ports (1..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width, a multiple of 8.
- RD_LAT, 1: SRAM read latency in cycles from ren asserted to r_data valid (1..4).

Ports:
- CLK  in  1  clock; all logic rising-edge.
- nRST  in  1  asynchronous active-low reset.
- port_ren  in  NPORTS  per-port read request.
- port_wen  in  NPORTS  per-port write request.
- port_addr  in  NPORTS*ADDR_W  flattened addresses; port i at [i*ADDR_W +: ADDR_W].
- port_w_data  in  NPORTS*DATA_W  flattened write data.
- port_ready  out  NPORTS  one-cycle completion pulse per port.
- port_r_data  out  DATA_W  read data, shared; valid when any port_ready is high for a read.
- sram_address  out  ADDR_W  to SRAM.
- sram_w_data  out  DATA_W  to SRAM.
- sram_ren  out  1  to SRAM.
- sram_wen  out  1  to SRAM.
- sram_r_data  in  DATA_W  from SRAM.

Behaviour:
- Reset:
  - All outputs 0 (port_ready, port_r_data, sram_address, sram_w_data, sram_ren, sram_wen).
  - State IDLE, round-robin pointer 0, wait counter 0.
  - Asserting nRST mid-transaction aborts it immediately; no ready is ever issued for the aborted request.
- Request definition: port i requests when port_ren[i] | port_wen[i]. If both are set, it is a write and ren is ignored. A requester holds its request and operands stable until it sees port_ready[i].
- IDLE:
  - If any request is present, grant the first requesting port at or after the pointer, wrapping modulo NPORTS.
  - Latch the grant index, address, write data and op. Go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Drive sram_address and sram_w_data from the latches.
  - Drive sram_wen=1 for a write, or sram_ren=1 for a read.
  - Next state: write goes to DONE; read goes to WAIT with counter=RD_LAT-1.
- WAIT:
  - sram_ren stays high and the address is held.
  - When counter==0, capture sram_r_data into port_r_data and go to DONE; otherwise decrement.
- DONE (exactly 1 cycle):
  - port_ready[grant]=1; all SRAM strobes low.
  - Pointer becomes (grant+1) mod NPORTS. Go to IDLE.
- Latency, with the request first seen in IDLE at cycle 0:
  - Write: ready at cycle 2.
  - Read: ready at cycle 2+RD_LAT.
  - Back-to-back minimum is 3 cycles per write and 3+RD_LAT per read.
- port_r_data holds its last captured value until the next read capture. It is not cleared by writes.
- Request dropped mid-transaction: the SRAM access still completes and ready still pulses; the requester ignores it.
- Request changed mid-transaction: ignored, because the operands are latched.
- At most one port_ready bit is high in any cycle. SRAM ren and wen are never both high.
- Fairness: with all ports continuously requesting, grants cycle 0,1,..,NPORTS-1. No port waits more than NPORTS-1 transactions.

Optional Feature:
- Macro DYT_SRAM_ARB_BYTE_STROBE_EN.
- When defined:
  - Adds input port_strb (NPORTS*DATA_W/8) and output sram_strb (DATA_W/8).
  - The strobe is latched with the write and driven on sram_strb during ACCESS; sram_strb is 0 at all other times.
  - A write with all-zero strobe keeps the same FSM timing and ready pulse, but sram_wen stays 0.
- When undefined: those ports do not exist, and every write is a full word.

Test Plan:
- Reset mid-read with NPORTS=2, RD_LAT=2: drop nRST during WAIT → all outputs 0 the same cycle, no port_ready pulse, next request granted from port 0.
- Single write then read, port 0, addr 0x100, data 0xDEADBEEF, RD_LAT=1 → sram_wen at cycle 1, ready at cycle 2; read ready at cycle 3 with port_r_data=0xDEADBEEF.
- Contention: ports 0 and 1 both hold reads from cycle 0 → port 0 served first, port 1 next, then port 0; never two readies in one cycle.
- RD_LAT=3 read → sram_ren high for 4 consecutive cycles, ready at cycle 5, data captured on the last ren cycle.
- Port with ren=wen=1, addr 0x40, data 0x12345678 → treated as a write; SRAM sees wen only, ren stays 0.
- With DYT_SRAM_ARB_BYTE_STROBE_EN: write strb=4'b0011 → sram_strb=0011 during ACCESS. Write strb=0 → sram_wen stays 0 and ready still arrives at cycle 2.
